// File: rtl/shreg_pkg.sv
// ---------------------------------------------------------------------------
// shreg_pkg
// Shared definitions for the universal burst shift register:
//   - MODE_* : 3-bit operation encodings used on the mode input
//   - state_t: burst engine states (ST_IDLE / ST_BUSY)
//   - is_shift_op(): true for the modes that move bits; only these give a
//     burst any work to do
// ---------------------------------------------------------------------------
package shreg_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;
    localparam logic [2:0] MODE_RSVD = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // HOLD, LOAD and the reserved code never shift, so a burst latched with
    // one of them collapses to a zero-length burst.
    function automatic logic is_shift_op(input logic [2:0] op);
        return (op == MODE_SHL) || (op == MODE_SHR) || (op == MODE_ROL) ||
               (op == MODE_ROR) || (op == MODE_ASR);
    endfunction

endpackage

// File: rtl/shreg_step.sv
// ---------------------------------------------------------------------------
// shreg_step
// Combinational next-value function of the shift register. One instance is
// shared by single-step operation and burst operation.
// Ports:
//   q        in  WIDTH  current register value
//   op       in  3      operation (MODE_* encoding)
//   d_in     in  WIDTH  parallel load data (used by MODE_LOAD)
//   ser_in_l in  1      bit entering at the MSB on SHR
//   ser_in_r in  1      bit entering at the LSB on SHL
//   q_next   out WIDTH  value after one application of op
// ---------------------------------------------------------------------------
module shreg_step
    import shreg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] d_in,
    input  logic             ser_in_l,
    input  logic             ser_in_r,
    output logic [WIDTH-1:0] q_next
);

    always_comb begin
        // NOTE: assigning a default before the case keeps every path driven,
        // so no latch is inferred even when new op codes are added later.
        q_next = q;
        case (op)
            MODE_LOAD: q_next = d_in;
            MODE_SHL:  q_next = {q[WIDTH-2:0], ser_in_r};
            MODE_SHR:  q_next = {ser_in_l, q[WIDTH-1:1]};
            MODE_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_ROR:  q_next = {q[0], q[WIDTH-1:1]};
            MODE_ASR:  q_next = {q[WIDTH-1], q[WIDTH-1:1]};
            default:   q_next = q;  // HOLD and reserved code
        endcase
    end

endmodule

// File: rtl/shift_reg_universal_burst.sv
// ---------------------------------------------------------------------------
// shift_reg_universal_burst
// WIDTH-bit universal shift register with parallel load, logical/arithmetic/
// rotate shifts, and a burst engine that repeats one shift op N times.
// Ports:
//   Clk        in  1      clock, rising edge
//   reset      in  1      synchronous active-high reset (highest priority)
//   en         in  1      clock enable; 0 freezes Q and burst progress
//   mode       in  3      operation select (MODE_* in shreg_pkg)
//   d_in       in  WIDTH  parallel load data
//   ser_in_r   in  1      serial bit entering LSB on SHL
//   ser_in_l   in  1      serial bit entering MSB on SHR
//   start      in  1      burst request, honoured only in IDLE with en=1
//   count      in  CW     burst repeat count, sampled with start
//   Q          out WIDTH  register contents
//   ser_out_l  out 1      Q[WIDTH-1]
//   ser_out_r  out 1      Q[0]
//   busy       out 1      high while a burst is in progress
//   done       out 1      one-cycle pulse when a burst completes
// ---------------------------------------------------------------------------
module shift_reg_universal_burst
    import shreg_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d_in,
    input  logic             ser_in_r,
    input  logic             ser_in_l,
    input  logic             start,
    input  logic [CW-1:0]    count,
    output logic [WIDTH-1:0] Q,
    output logic             ser_out_l,
    output logic             ser_out_r,
    output logic             busy,
    output logic             done
);

    state_t           r_state;
    logic [2:0]       r_op;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_q;
    logic             r_done;

    state_t           w_state_nxt;
    logic [2:0]       w_op_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_done_nxt;
    logic [2:0]       w_op_sel;
    logic [WIDTH-1:0] w_q_step;

    // While bursting, the latched op drives the shared step function and the
    // live mode input is ignored.
    assign w_op_sel = (r_state == ST_BUSY) ? r_op : mode;

    shreg_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .q        (r_q),
        .op       (w_op_sel),
        .d_in     (d_in),
        .ser_in_l (ser_in_l),
        .ser_in_r (ser_in_r),
        .q_next   (w_q_step)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt    = r_op;
        w_cnt_nxt   = r_cnt;
        w_q_nxt     = r_q;
        w_done_nxt  = 1'b0;   // done is a pulse: low unless set below

        case (r_state)
            ST_IDLE: begin
                if (en) begin
                    if (start) begin
                        // start wins over the step: Q is untouched this edge
                        w_state_nxt = ST_BUSY;
                        w_op_nxt    = mode;
                        w_cnt_nxt   = is_shift_op(mode) ? count : '0;
                    end else begin
                        w_q_nxt = w_q_step;
                    end
                end
            end
            ST_BUSY: begin
                if (en) begin
                    if (r_cnt != '0) begin
                        w_q_nxt   = w_q_step;
                        w_cnt_nxt = r_cnt - CW'(1);
                    end else begin
                        // extra edge after the last shift closes the burst
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge Clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_op    <= MODE_HOLD;
            r_cnt   <= '0;
            r_q     <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_op    <= w_op_nxt;
            r_cnt   <= w_cnt_nxt;
            r_q     <= w_q_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign Q         = r_q;
    assign ser_out_l = r_q[WIDTH-1];
    assign ser_out_r = r_q[0];
    assign busy      = (r_state == ST_BUSY);
    assign done      = r_done;

endmodule

// File: tb/tb_shift_reg_universal_burst.sv
// ---------------------------------------------------------------------------
// tb_shift_reg_universal_burst
// Scoreboard bench: each driven cycle pushes the expected post-edge outputs
// from a behavioural model; a monitor pops and compares after every edge.
// Directed sequences add constant-valued checks for the key scenarios.
// ---------------------------------------------------------------------------
module tb_shift_reg_universal_burst;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    localparam logic [2:0] HOLD = 3'd0, LOAD = 3'd1, SHL = 3'd2, SHR = 3'd3,
                           ROL  = 3'd4, ROR  = 3'd5, ASR = 3'd6;

    logic          Clk = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b0;
    logic [2:0]    mode = 3'd0;
    logic [W-1:0]  d_in = '0;
    logic          ser_in_r = 1'b0;
    logic          ser_in_l = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] count = '0;
    logic [W-1:0]  Q;
    logic          ser_out_l, ser_out_r, busy, done;

    shift_reg_universal_burst #(.WIDTH(W)) dut (
        .Clk       (Clk),
        .reset     (reset),
        .en        (en),
        .mode      (mode),
        .d_in      (d_in),
        .ser_in_r  (ser_in_r),
        .ser_in_l  (ser_in_l),
        .start     (start),
        .count     (count),
        .Q         (Q),
        .ser_out_l (ser_out_l),
        .ser_out_r (ser_out_r),
        .busy      (busy),
        .done      (done)
    );

    always #5 Clk = ~Clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Next-cycle stimulus, set by the sequences and applied by tick().
    logic          n_rst = 1'b1, n_en = 1'b1, n_sl = 1'b0, n_sr = 1'b0, n_start = 1'b0;
    logic [2:0]    n_mode = HOLD;
    logic [W-1:0]  n_d = '0;
    logic [CW-1:0] n_cnt = '0;

    // Reference model: register value, burst flag, shifts still owed.
    logic [W-1:0]  m_q = '0;
    logic          m_busy = 1'b0, m_done = 1'b0;
    int            m_left = 0;
    logic [2:0]    m_op = HOLD;

    typedef struct packed {
        logic [W-1:0] q;
        logic         busy;
        logic         done;
        logic         sol;
        logic         sor;
    } obs_t;

    obs_t sb[$];

    function automatic logic [W-1:0] apply_op(input logic [W-1:0] q, input logic [2:0] op,
                                              input logic [W-1:0] d, input logic sl, input logic sr);
        logic [2*W-1:0]      dbl;
        logic signed [W-1:0] s;
        dbl = {q, q};
        s   = q;
        case (op)
            LOAD:    return d;
            SHL:     return W'((q << 1) | W'(sr));
            SHR:     return W'((q >> 1) | (W'(sl) << (W - 1)));
            ROL:     return dbl[2*W-2 -: W];
            ROR:     return dbl[W:1];
            ASR:     return W'(s >>> 1);
            default: return q;
        endcase
    endfunction

    function automatic bit moves_bits(input logic [2:0] op);
        return op inside {SHL, SHR, ROL, ROR, ASR};
    endfunction

    // Apply stimulus just after a falling edge, advance the model over the
    // coming rising edge and queue what the DUT should show afterwards.
    task automatic tick();
        obs_t e;
        @(negedge Clk);
        reset = n_rst; en = n_en; mode = n_mode; d_in = n_d;
        ser_in_l = n_sl; ser_in_r = n_sr; start = n_start; count = n_cnt;
        if (n_rst) begin
            m_q = '0; m_busy = 1'b0; m_done = 1'b0; m_left = 0;
        end else begin
            m_done = 1'b0;
            if (n_en && !m_busy) begin
                if (n_start) begin
                    m_busy = 1'b1;
                    m_op   = n_mode;
                    m_left = moves_bits(n_mode) ? int'(n_cnt) : 0;
                end else begin
                    m_q = apply_op(m_q, n_mode, n_d, n_sl, n_sr);
                end
            end else if (n_en && m_busy) begin
                if (m_left > 0) begin
                    m_q = apply_op(m_q, m_op, n_d, n_sl, n_sr);
                    m_left--;
                end else begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end
        end
        e.q = m_q; e.busy = m_busy; e.done = m_done; e.sol = m_q[W-1]; e.sor = m_q[0];
        sb.push_back(e);
    endtask

    // Monitor: compare everything the DUT presents after each rising edge.
    initial begin
        obs_t e, a;
        forever begin
            @(posedge Clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                a = {Q, busy, done, ser_out_l, ser_out_r};
                check("cycle_outputs", 32'(a), 32'(e));
            end
        end
    end

    // Directed post-edge check against constants from the test plan.
    task automatic post(input string name, input logic [W-1:0] q, input logic b, input logic dn);
        @(posedge Clk);
        #2;
        check({name, "_q"}, 32'(Q), 32'(q));
        check({name, "_busy"}, 32'(busy), 32'(b));
        check({name, "_done"}, 32'(done), 32'(dn));
    endtask

    task automatic load(input logic [W-1:0] v);
        n_start = 1'b0; n_mode = LOAD; n_d = v; tick();
        n_mode = HOLD;
    endtask

    task automatic burst_start(input logic [2:0] op, input int n);
        n_start = 1'b1; n_mode = op; n_cnt = CW'(n); tick();
        n_start = 1'b0;
    endtask

    initial begin
        // Reset with LOAD FF pending: reset must win.
        n_rst = 1'b1; n_mode = LOAD; n_d = 8'hFF;
        tick(); tick();
        post("reset", 8'h00, 1'b0, 1'b0);
        n_rst = 1'b0; n_mode = HOLD;

        // Single-step operations.
        load(8'hA5);                         post("load_a5", 8'hA5, 1'b0, 1'b0);
        n_mode = SHL; n_sr = 1'b1; tick();   post("shl", 8'h4B, 1'b0, 1'b0);
        n_sr = 1'b0;
        load(8'h96);                         post("load_96", 8'h96, 1'b0, 1'b0);
        check("ser_out_l_96", 32'(ser_out_l), 32'(1'b1));
        check("ser_out_r_96", 32'(ser_out_r), 32'(1'b0));
        n_mode = ASR; tick();                post("asr", 8'hCB, 1'b0, 1'b0);
        load(8'h96); n_mode = SHR; n_sl = 1'b0; tick();
        post("shr", 8'h4B, 1'b0, 1'b0);
        load(8'h96); n_mode = ROL; tick();   post("rol", 8'h2D, 1'b0, 1'b0);

        // Burst ROR x3 with mode toggling while busy.
        load(8'h81);
        burst_start(ROR, 3);                 post("ror_start", 8'h81, 1'b1, 1'b0);
        n_mode = LOAD; n_d = 8'h00; tick();  post("ror_1", 8'hC0, 1'b1, 1'b0);
        n_mode = SHL; tick();                post("ror_2", 8'h60, 1'b1, 1'b0);
        n_mode = ASR; tick();                post("ror_3", 8'h30, 1'b1, 1'b0);
        n_mode = HOLD; tick();               post("ror_done", 8'h30, 1'b0, 1'b1);
        tick();                              post("ror_after", 8'h30, 1'b0, 1'b0);

        // Stall two cycles mid-burst: done arrives two cycles later.
        load(8'h81);
        burst_start(ROR, 3);
        tick();                              post("stall_1", 8'hC0, 1'b1, 1'b0);
        n_en = 1'b0; tick(); tick();         post("stall_hold", 8'hC0, 1'b1, 1'b0);
        n_en = 1'b1; tick(); tick();         post("stall_3", 8'h30, 1'b1, 1'b0);
        tick();                              post("stall_done", 8'h30, 1'b0, 1'b1);

        // Zero-length burst.
        burst_start(SHL, 0);                 post("cnt0_busy", 8'h30, 1'b1, 1'b0);
        tick();                              post("cnt0_done", 8'h30, 1'b0, 1'b1);

        // Count beyond WIDTH fills with the serial bit.
        load(8'h00);
        n_sr = 1'b1;
        burst_start(SHL, 9);
        for (int i = 0; i < 9; i++) tick();
        tick();                              post("shl9_done", 8'hFF, 1'b0, 1'b1);
        n_sr = 1'b0;

        // Reset after the second shift aborts without a done pulse.
        load(8'hF0);
        burst_start(SHL, 4);
        tick(); tick();                      post("abort_pre", 8'hC0, 1'b1, 1'b0);
        n_rst = 1'b1; tick();                post("abort_rst", 8'h00, 1'b0, 1'b0);
        n_rst = 1'b0; tick(); tick();        post("abort_after", 8'h00, 1'b0, 1'b0);

        // Back-to-back: second start in the done cycle.
        load(8'h81);
        burst_start(ROL, 2);
        tick(); tick();                      post("b2b_a", 8'h06, 1'b1, 1'b0);
        tick();                              post("b2b_a_done", 8'h06, 1'b0, 1'b1);
        burst_start(ROR, 1);                 post("b2b_b_start", 8'h06, 1'b1, 1'b0);
        tick();                              post("b2b_b_1", 8'h03, 1'b1, 1'b0);
        tick();                              post("b2b_b_done", 8'h03, 1'b0, 1'b1);

        // Randomised traffic, checked by the scoreboard alone.
        for (int i = 0; i < 800; i++) begin
            n_rst   = ($urandom_range(0, 99) == 0);
            n_en    = ($urandom_range(0, 9) != 0);
            n_mode  = 3'($urandom_range(0, 7));
            n_d     = W'($urandom);
            n_sl    = 1'($urandom);
            n_sr    = 1'($urandom);
            n_start = ($urandom_range(0, 4) == 0);
            n_cnt   = CW'($urandom_range(0, (1 << CW) - 1));
            tick();
        end

        n_rst = 1'b0; n_en = 1'b1; n_start = 1'b0; n_mode = HOLD;
        repeat (3) @(posedge Clk);
        #3;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_reg_universal_burst.md
Name: shift_reg_universal_burst

Overview:
Parametrised universal shift register that generalises the lab's sync-reset D register. It has WIDTH bits, parallel load, and logical, arithmetic and rotate shifts in both directions. It also has a burst engine that applies one shift operation N times under a start/busy/done handshake. It sits in the lab datapath as the shifting stage between switch/parallel inputs and LED/serial outputs.

Parameters:
WIDTH, 8, register width in bits (>=2)
CW, $clog2(WIDTH+1), width of burst count input (derived, not overridden)

Ports:
Clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
en  input  1  clock enable; 0 freezes Q and burst progress
mode  input  3  operation select (encoding below)
d_in  input  WIDTH  parallel load data
ser_in_r  input  1  bit entering at LSB on SHL
ser_in_l  input  1  bit entering at MSB on SHR
start  input  1  burst request, sampled only in IDLE
count  input  CW  burst repeat count, sampled with start
Q  output  WIDTH  register contents
ser_out_l  output  1  Q[WIDTH-1] (combinational from Q)
ser_out_r  output  1  Q[0] (combinational from Q)
busy  output  1  high while a burst is in progress
done  output  1  single-cycle pulse when a burst completes

Behaviour:
- Reset: clock edge with reset=1 forces Q=0, busy=0, done=0, state IDLE, internal count=0. Reset has priority over en, start and mode. Reset mid-burst aborts the burst with no done pulse.
- Mode encoding:
  - 000 HOLD
  - 001 LOAD (Q<=d_in)
  - 010 SHL (Q<={Q[W-2:0],ser_in_r})
  - 011 SHR (Q<={ser_in_l,Q[W-1:1]})
  - 100 ROL
  - 101 ROR
  - 110 ASR (MSB replicated)
  - 111 reserved, behaves as HOLD
- States: IDLE and BUSY.
- IDLE, en=0: nothing changes, and start is ignored.
- IDLE, en=1, start=0: one step of mode per edge, with single-cycle latency (result visible after the edge).
- IDLE, en=1, start=1:
  - start takes priority over the step; Q is unchanged on this edge.
  - mode and count are latched; busy goes 1 and state becomes BUSY.
  - If the latched mode is HOLD, LOAD or 111, the burst is treated as count=0.
- BUSY, en=1, internal count>0: apply the latched op once and decrement the count.
- BUSY, en=1, internal count==0: busy<=0, done<=1 for exactly one cycle, return to IDLE.
- BUSY, en=0: stall, with Q, count and busy held.
- Timing: a burst of N takes N+1 enabled edges after the start edge to assert done. busy is high for N+1 cycles; Q holds its final value from the Nth shift.
- While BUSY, the mode, start, count and d_in inputs are ignored.
- A start in the same cycle that done is high is accepted, because the state is already IDLE.
- Burst count values >WIDTH are legal. SHL/SHR then fill entirely with the serial input; ASR saturates to all-sign; rotates wrap modulo WIDTH.
- ser_in_l and ser_in_r are sampled live on every burst shift, not latched.
- done is 0 at all other times.

Decomposition:
- Package shreg_pkg: mode localparams MODE_HOLD..MODE_ASR, state encoding ST_IDLE/ST_BUSY.
- One sub-module, shreg_step: a combinational next-value function (inputs q, op, ser_in_l, ser_in_r; output q_next). It is shared by the step path and the burst path. The top level holds the FSM, counter and Q register.

Test Plan:
- Reset values: WIDTH=8, assert reset 2 cycles with mode=LOAD, d_in=FF -> Q=00, busy=0, done=0.
- Step ops: LOAD A5 -> Q=A5; then SHL with ser_in_r=1 -> Q=4B.
  - From Q=96: ASR -> CB; SHR with ser_in_l=0 -> 4B; ROL -> 2D.
  - From Q=96: ser_out_l=1 and ser_out_r=0.
- Burst ROR: Q=81, start with mode=ROR, count=3 -> Q sequence C0, 60, 30; busy high 4 cycles; done pulses once with Q=30; mode changes during BUSY have no effect.
- Burst stall and boundaries:
  - en low for 2 cycles mid-burst -> Q and busy hold, and done is delayed by exactly 2 cycles.
  - count=0 -> Q unchanged, busy 1 cycle, then done.
  - Burst SHL with count=9 and ser_in_r=1 -> Q=FF.
- Reset mid-burst: Q=F0, burst SHL count=4, reset after 2nd shift -> Q=00, busy=0, and no done pulse follows.
- Back-to-back: start asserted in the done cycle -> new burst accepted, busy rises the next cycle, and both bursts complete with correct Q.
